edge_waveform_gen: RTL

//  Drive-side counterpart of both_edgedetector: turns single-cycle rise/fall

---
 rtl/edge_pkg.sv | 17 +
 rtl/hold_timer.sv | 38 +++
 rtl/edge_waveform_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// State encodings and helpers shared by the waveform generator and its tests.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package edge_pkg;

  // Output level state; encoding equals the driven level.
  typedef enum logic {
    S_LOW  = 1'b0,
    S_HIGH = 1'b1
  } state_t;

  // Larger of two integers, used to size the hold timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
// Latency: load value visible one cycle after the load posedge.
// Backpressure: none; load wins over decrement.
module hold_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/edge_waveform_gen.sv
// Turns single-cycle rise/fall requests into a level with min high/low widths.
// Latency: accepted edge appears on signal_out one cycle after the sampling posedge.
// Backpressure: one early opposite request is queued; further ones pulse drop_err.
module edge_waveform_gen
  import edge_pkg::*;
#(
  parameter int MIN_HIGH = 3,
  parameter int MIN_LOW  = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rise_req,
  input  logic             fall_req,
  output logic             signal_out,
  output logic             busy,
  output logic             drop_err,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt
);

  localparam int HOLD_W = $clog2(max_int(MIN_HIGH, MIN_LOW)) + 1;

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0]   fall_cnt_q, fall_cnt_d;

  logic               hold_done;
  logic               edge_go;
  logic [HOLD_W-1:0]  load_val;
  logic               both_req;
  logic               opp_req;

  hold_timer #(
    .W(HOLD_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (edge_go),
    .load_val (load_val),
    .done     (hold_done)
  );

  // Request arbitration: execute, queue or discard; next level and counters.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    edge_go    = 1'b0;
    load_val   = '0;
    both_req   = rise_req & fall_req;
    // A request is "opposite" only if it would change the current level.
    opp_req    = (state_q == S_LOW) ? rise_req : fall_req;
    // Simultaneous rise+fall is ambiguous; a second early request has no slot.
    drop_d     = both_req | (opp_req & pending_q);

    if (hold_done && (pending_q || (opp_req && !both_req))) begin
      edge_go   = 1'b1;
      pending_d = 1'b0;
      if (state_q == S_LOW) begin
        state_d    = S_HIGH;
        rise_cnt_d = rise_cnt_q + CNT_W'(1);
        load_val   = HOLD_W'(MIN_HIGH - 1);
      end else begin
        state_d    = S_LOW;
        fall_cnt_d = fall_cnt_q + CNT_W'(1);
        load_val   = HOLD_W'(MIN_LOW - 1);
      end
    end else if (opp_req && !both_req && !pending_q) begin
      // hold_done is necessarily 0 here: park the request until the window ends.
      pending_d = 1'b1;
    end
  end

  // State, pending flag, error pulse and edge counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_LOW;
      pending_q  <= 1'b0;
      drop_q     <= 1'b0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end

  assign signal_out = (state_q == S_HIGH);
  assign busy       = !hold_done | pending_q;
  assign drop_err   = drop_q;
  assign rise_cnt   = rise_cnt_q;
  assign fall_cnt   = fall_cnt_q;

endmodule
